rob_retire: RTL and testbench
=============================

Name: rob_retire

Overview:
- In-order reorder buffer and retire stage of the dual-issue out-of-order RISC-V core.
- Accepts the two renamed instructions that rename emits per enabled cycle and tracks completion reports from execute.
- Retires up to two instructions per cycle in program order.
- Returns each retired instruction's superseded physical register (old_pd) to the rename free pool over the rt_flag_1/fp_i_1 and rt_flag_2/fp_i_2 interface.

Parameters:
- DEPTH, 16: ROB entries; power of two, ≥4.
- PREG_W, 6: physical register tag width (64 pregs).
- AREG_W, 5: architectural register index width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- en_flag_i  in  1  dispatch pair valid; slot 1 is older than slot 2.
- rd_1, rd_2  in  AREG_W  destination architectural registers.
- pd_1, pd_2  in  PREG_W  newly allocated pregs.
- old_pd_1, old_pd_2  in  PREG_W  previous mappings of rd_1/rd_2.
- rob_idx_1, rob_idx_2  out  log2(DEPTH)  entry index assigned to each slot (tail, tail+1); combinational.
- stall_o  out  1  fewer than 2 free entries; combinational from the registered count.
- cmp_valid_1, cmp_valid_2  in  1  completion strobes from execute.
- cmp_idx_1, cmp_idx_2  in  log2(DEPTH)  entries completing.
- rt_flag_1, rt_flag_2  out  1  free-pool release strobe.
- fp_i_1, fp_i_2  out  PREG_W  preg to release.
- rt_cnt_o  out  2  instructions retired this cycle (0..2).
- count_o  out  log2(DEPTH)+1  occupied entries.
- empty_o  out  1  count_o == 0.

Behaviour:
- Storage:
  - Circular buffer; each entry holds valid, done, rd, pd, old_pd.
  - head/tail pointers are log2(DEPTH)+1 bits; the MSB is the wrap bit. Index = low bits.
- Reset (async, any time including mid-operation):
  - Clear all valid/done bits; head = tail = 0.
  - Outputs: rt_flag_x = 0, fp_i_x = 0, rt_cnt_o = 0, count_o = 0, empty_o = 1, stall_o = 0.
- Dispatch:
  - Occurs when en_flag_i && !stall_o.
  - Write slot 1 to entry [tail] and slot 2 to entry [tail+1], both valid=1, done=0; tail += 2.
  - When en_flag_i && stall_o, the pair is dropped with no state change; upstream must hold the pair.
  - stall_o uses pre-update occupancy. Same-cycle retires do not relieve it (conservative).
- Completion:
  - cmp_valid_x sets done=1 on entry [cmp_idx_x] at the edge, only if that entry is valid. Otherwise ignored.
  - Both ports may target different entries in the same cycle. Same index on both ports = single set.
- Retire decision (combinational from registered state):
  - r1 = entry[head].valid && entry[head].done.
  - r2 = r1 && entry[head+1].valid && entry[head+1].done.
  - Never retire slot 2 without slot 1.
  - No completion bypass: an entry completing at edge E is retire-eligible at the earliest for edge E+1.
- Retire update (at edge):
  - Clear valid/done of retired entries; head += r1 + r2.
  - Register outputs: rt_cnt_o = r1 + r2.
  - rt_flag_1 = r1 && rd[head] != 0; fp_i_1 = old_pd[head].
  - rt_flag_2 = r2 && rd[head+1] != 0; fp_i_2 = old_pd[head+1].
  - When rd == 0, the entry retires but no preg is released, and fp_i_x = 0.
  - Strobes are single-cycle; fp_i_x = 0 whenever the corresponding rt_flag_x = 0.
- Count:
  - count_o' = count_o + 2·dispatch − rt_cnt, computed in log2(DEPTH)+1 bits with no overflow.
  - Dispatch and retire in the same cycle are both honoured.
- Wrap-around:
  - Pointer increments wrap modulo 2·DEPTH; tail+1 and head+1 index modulo DEPTH.
  - Full when tail−head == DEPTH; empty when equal.

Optional Feature:
- Macro ROB_PERF_CNT_EN.
- Defined: adds output retired_total_o [31:0]. It is reset to 0 asynchronously, increments by rt_cnt_o each cycle, and wraps at 2^32.
- Undefined: the port and counter do not exist. All other behaviour is identical.

Test Plan:
- Reset: assert rst mid-stream with 6 entries valid → next cycle count_o=0, empty_o=1, rt_flag_1/2=0, and a subsequent dispatch gets rob_idx_1=0, rob_idx_2=1.
- In-order retire: dispatch (rd 3,pd 32,old 3)/(rd 4,pd 33,old 4); complete idx 1 only → no retire; then complete idx 0 → next edge rt_flag_1=1 fp_i_1=3, rt_flag_2=1 fp_i_2=4, rt_cnt_o=2.
- x0 destination: dispatch rd_1=0 and rd_2=5 (old_pd 5); complete both → rt_cnt_o=2, rt_flag_1=0, fp_i_1=0, rt_flag_2=1, fp_i_2=5.
- Full/stall: DEPTH=16; dispatch 8 pairs with no completions → count_o=16, stall_o=1; a 9th en_flag_i pair is dropped and count_o stays 16; complete idx 0,1 → after retire stall_o=0.
- Wrap-around: run 20 pairs with back-to-back completion → rob_idx wraps 14,15 → 0,1, no lost or duplicated fp_i values, and 40 retirements total (retired_total_o=40 with ROB_PERF_CNT_EN).
- Completion to invalid entry: cmp_valid_1 on an empty idx 7, then dispatch into idx 7 → the new entry does not retire until it is completed itself.

Source files
------------

// File: rtl/rob_retire.sv
// In-order reorder buffer and dual retire stage; releases superseded pregs to the rename free pool.
// Optional retire counter: define ROB_PERF_CNT_EN to add retired_total_o.
module rob_retire #(
    parameter  int DEPTH  = 16,
    parameter  int PREG_W = 6,
    parameter  int AREG_W = 5,
    localparam int IDX_W  = $clog2(DEPTH),
    localparam int PTR_W  = IDX_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_flag_i,
    input  logic [AREG_W-1:0] rd_1,
    input  logic [AREG_W-1:0] rd_2,
    input  logic [PREG_W-1:0] pd_1,
    input  logic [PREG_W-1:0] pd_2,
    input  logic [PREG_W-1:0] old_pd_1,
    input  logic [PREG_W-1:0] old_pd_2,
    output logic [IDX_W-1:0]  rob_idx_1,
    output logic [IDX_W-1:0]  rob_idx_2,
    output logic              stall_o,
    input  logic              cmp_valid_1,
    input  logic              cmp_valid_2,
    input  logic [IDX_W-1:0]  cmp_idx_1,
    input  logic [IDX_W-1:0]  cmp_idx_2,
    output logic              rt_flag_1,
    output logic              rt_flag_2,
    output logic [PREG_W-1:0] fp_i_1,
    output logic [PREG_W-1:0] fp_i_2,
    output logic [1:0]        rt_cnt_o,
    output logic [PTR_W-1:0]  count_o,
`ifdef ROB_PERF_CNT_EN
    output logic [31:0]       retired_total_o,
`endif
    output logic              empty_o
);

    localparam logic [PTR_W-1:0] STALL_LVL = PTR_W'(DEPTH - 1);

    logic [DEPTH-1:0]  r_valid;
    logic [DEPTH-1:0]  r_done;
    logic [AREG_W-1:0] r_rd    [DEPTH];
    logic [PREG_W-1:0] r_pd    [DEPTH];
    logic [PREG_W-1:0] r_oldPd [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;

    logic [IDX_W-1:0]  w_h0;
    logic [IDX_W-1:0]  w_h1;
    logic [IDX_W-1:0]  w_t0;
    logic [IDX_W-1:0]  w_t1;
    logic              w_r1;
    logic              w_r2;
    logic [1:0]        w_rtCnt;
    logic              w_dispatch;

    // Occupancy is the pointer distance; the wrap bit separates full from empty.
    assign count_o    = r_tail - r_head;
    assign empty_o    = (count_o == '0);
    assign stall_o    = (count_o >= STALL_LVL);
    assign w_dispatch = en_flag_i && !stall_o;

    assign w_t0      = r_tail[IDX_W-1:0];
    assign w_t1      = w_t0 + IDX_W'(1);
    assign w_h0      = r_head[IDX_W-1:0];
    assign w_h1      = w_h0 + IDX_W'(1);
    assign rob_idx_1 = w_t0;
    assign rob_idx_2 = w_t1;

    assign w_r1    = r_valid[w_h0] && r_done[w_h0];
    assign w_r2    = w_r1 && r_valid[w_h1] && r_done[w_h1];
    assign w_rtCnt = {1'b0, w_r1} + {1'b0, w_r2};

    // Completion, then retire clear, then dispatch: later writes win on overlapping entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid   <= '0;
            r_done    <= '0;
            r_head    <= '0;
            r_tail    <= '0;
            rt_flag_1 <= 1'b0;
            rt_flag_2 <= 1'b0;
            fp_i_1    <= '0;
            fp_i_2    <= '0;
            rt_cnt_o  <= '0;
        end else begin
            if (cmp_valid_1 && r_valid[cmp_idx_1]) r_done[cmp_idx_1] <= 1'b1;
            if (cmp_valid_2 && r_valid[cmp_idx_2]) r_done[cmp_idx_2] <= 1'b1;
            if (w_r1) begin
                r_valid[w_h0] <= 1'b0;
                r_done[w_h0]  <= 1'b0;
            end
            if (w_r2) begin
                r_valid[w_h1] <= 1'b0;
                r_done[w_h1]  <= 1'b0;
            end
            if (w_dispatch) begin
                r_valid[w_t0] <= 1'b1;
                r_done[w_t0]  <= 1'b0;
                r_valid[w_t1] <= 1'b1;
                r_done[w_t1]  <= 1'b0;
                r_tail        <= r_tail + PTR_W'(2);
            end
            r_head    <= r_head + PTR_W'(w_rtCnt);
            rt_cnt_o  <= w_rtCnt;
            rt_flag_1 <= w_r1 && (r_rd[w_h0] != '0);
            rt_flag_2 <= w_r2 && (r_rd[w_h1] != '0);
            fp_i_1    <= (w_r1 && (r_rd[w_h0] != '0)) ? r_oldPd[w_h0] : '0;
            fp_i_2    <= (w_r2 && (r_rd[w_h1] != '0)) ? r_oldPd[w_h1] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_dispatch) begin
            r_rd[w_t0]    <= rd_1;
            r_pd[w_t0]    <= pd_1;
            r_oldPd[w_t0] <= old_pd_1;
            r_rd[w_t1]    <= rd_2;
            r_pd[w_t1]    <= pd_2;
            r_oldPd[w_t1] <= old_pd_2;
        end
    end

`ifdef ROB_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) retired_total_o <= '0;
        else     retired_total_o <= retired_total_o + 32'(rt_cnt_o);
    end
`endif

endmodule

// File: tb/tb_rob_retire.sv
// Directed bench for rob_retire; released pregs are checked in order against a scoreboard queue.
module tb_rob_retire;

    typedef struct packed {
        logic       rel;
        logic [5:0] pd;
    } sbEntry_t;

    logic       clock;
    logic       reset;
    logic       en_flag_i;
    logic [4:0] rd_1, rd_2;
    logic [5:0] pd_1, pd_2, old_pd_1, old_pd_2;
    logic [3:0] rob_idx_1, rob_idx_2;
    logic       stall_o;
    logic       cmp_valid_1, cmp_valid_2;
    logic [3:0] cmp_idx_1, cmp_idx_2;
    logic       rt_flag_1, rt_flag_2;
    logic [5:0] fp_i_1, fp_i_2;
    logic [1:0] rt_cnt_o;
    logic [4:0] count_o;
    logic       empty_o;
`ifdef ROB_PERF_CNT_EN
    logic [31:0] retired_total_o;
`endif

    sbEntry_t sb[$];
    int assertCount = 0;
    int failCount   = 0;
    int popCount    = 0;

    rob_retire #(.DEPTH(16), .PREG_W(6), .AREG_W(5)) dut (
        .clk(clock), .rst(reset), .en_flag_i(en_flag_i),
        .rd_1(rd_1), .rd_2(rd_2), .pd_1(pd_1), .pd_2(pd_2),
        .old_pd_1(old_pd_1), .old_pd_2(old_pd_2),
        .rob_idx_1(rob_idx_1), .rob_idx_2(rob_idx_2), .stall_o(stall_o),
        .cmp_valid_1(cmp_valid_1), .cmp_valid_2(cmp_valid_2),
        .cmp_idx_1(cmp_idx_1), .cmp_idx_2(cmp_idx_2),
        .rt_flag_1(rt_flag_1), .rt_flag_2(rt_flag_2),
        .fp_i_1(fp_i_1), .fp_i_2(fp_i_2), .rt_cnt_o(rt_cnt_o),
        .count_o(count_o),
`ifdef ROB_PERF_CNT_EN
        .retired_total_o(retired_total_o),
`endif
        .empty_o(empty_o)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic popCheck(input string tag, input logic flag, input logic [5:0] fp);
        sbEntry_t e;
        checkOutput({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            popCount++;
            checkOutput({tag, "_flag"}, 32'(flag), 32'(e.rel));
            checkOutput({tag, "_fp"}, 32'(fp), e.rel ? 32'(e.pd) : 32'd0);
        end
    endtask

    // Every retirement reported by the DUT is matched against the oldest expected release.
    task automatic checkRetire();
        checkOutput("rt_cnt_range", 32'(rt_cnt_o <= 2'd2), 32'd1);
        if (rt_cnt_o == 2'd0) begin
            checkOutput("idle_flag1", 32'(rt_flag_1), 32'd0);
            checkOutput("idle_flag2", 32'(rt_flag_2), 32'd0);
        end
        if (rt_cnt_o >= 2'd1) popCheck("slot1", rt_flag_1, fp_i_1);
        if (rt_cnt_o == 2'd1) checkOutput("single_flag2", 32'(rt_flag_2), 32'd0);
        if (rt_cnt_o == 2'd2) popCheck("slot2", rt_flag_2, fp_i_2);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        checkRetire();
    endtask

    task automatic applyStimulus(input logic [4:0] r1, input logic [5:0] p1, input logic [5:0] o1,
                                 input logic [4:0] r2, input logic [5:0] p2, input logic [5:0] o2,
                                 input bit accept);
        en_flag_i = 1'b1;
        rd_1 = r1; pd_1 = p1; old_pd_1 = o1;
        rd_2 = r2; pd_2 = p2; old_pd_2 = o2;
        if (accept) begin
            sb.push_back('{rel: (r1 != 5'd0), pd: o1});
            sb.push_back('{rel: (r2 != 5'd0), pd: o2});
        end
        step();
        en_flag_i = 1'b0;
    endtask

    task automatic completeIdx(input logic [3:0] i1, input logic v1, input logic [3:0] i2, input logic v2);
        cmp_valid_1 = v1; cmp_idx_1 = i1;
        cmp_valid_2 = v2; cmp_idx_2 = i2;
        step();
        cmp_valid_1 = 1'b0;
        cmp_valid_2 = 1'b0;
    endtask

    initial begin
        logic [3:0] wIdx;
        logic [3:0] prevIdx;
        int popsBefore;

        reset = 1'b1; en_flag_i = 1'b0;
        rd_1 = '0; rd_2 = '0; pd_1 = '0; pd_2 = '0; old_pd_1 = '0; old_pd_2 = '0;
        cmp_valid_1 = 1'b0; cmp_valid_2 = 1'b0; cmp_idx_1 = '0; cmp_idx_2 = '0;
        repeat (2) @(posedge clock);
        #1;
        checkOutput("rst_count", 32'(count_o), 32'd0);
        checkOutput("rst_empty", 32'(empty_o), 32'd1);
        checkOutput("rst_stall", 32'(stall_o), 32'd0);
        checkOutput("rst_rtcnt", 32'(rt_cnt_o), 32'd0);
        checkOutput("rst_flag1", 32'(rt_flag_1), 32'd0);
        checkOutput("rst_fp1", 32'(fp_i_1), 32'd0);
        reset = 1'b0;

        $display("[TB] in-order retire");
        checkOutput("io_idx1", 32'(rob_idx_1), 32'd0);
        checkOutput("io_idx2", 32'(rob_idx_2), 32'd1);
        applyStimulus(5'd3, 6'd32, 6'd3, 5'd4, 6'd33, 6'd4, 1'b1);
        checkOutput("io_count", 32'(count_o), 32'd2);
        completeIdx(4'd1, 1'b1, 4'd0, 1'b0);
        checkOutput("io_young_only_a", 32'(rt_cnt_o), 32'd0);
        step();
        checkOutput("io_young_only_b", 32'(rt_cnt_o), 32'd0);
        completeIdx(4'd0, 1'b1, 4'd0, 1'b0);
        checkOutput("io_no_bypass", 32'(rt_cnt_o), 32'd0);
        step();
        checkOutput("io_rtcnt", 32'(rt_cnt_o), 32'd2);
        checkOutput("io_fp1", 32'(fp_i_1), 32'd3);
        checkOutput("io_fp2", 32'(fp_i_2), 32'd4);
        checkOutput("io_empty", 32'(empty_o), 32'd1);

        $display("[TB] x0 destination");
        checkOutput("x0_idx1", 32'(rob_idx_1), 32'd2);
        applyStimulus(5'd0, 6'd34, 6'd7, 5'd5, 6'd35, 6'd5, 1'b1);
        completeIdx(4'd2, 1'b1, 4'd3, 1'b1);
        step();
        checkOutput("x0_rtcnt", 32'(rt_cnt_o), 32'd2);
        checkOutput("x0_flag1", 32'(rt_flag_1), 32'd0);
        checkOutput("x0_fp1", 32'(fp_i_1), 32'd0);
        checkOutput("x0_flag2", 32'(rt_flag_2), 32'd1);
        checkOutput("x0_fp2", 32'(fp_i_2), 32'd5);

        $display("[TB] full and stall");
        for (int k = 0; k < 8; k++) begin
            if (k == 7) begin
                checkOutput("full_count14", 32'(count_o), 32'd14);
                checkOutput("full_nostall14", 32'(stall_o), 32'd0);
            end
            applyStimulus(5'(k + 1), 6'(40 + k), 6'(10 + 2 * k), 5'(k + 10), 6'(50 + k), 6'(11 + 2 * k), 1'b1);
        end
        checkOutput("full_count16", 32'(count_o), 32'd16);
        checkOutput("full_stall", 32'(stall_o), 32'd1);
        applyStimulus(5'd9, 6'd60, 6'd61, 5'd9, 6'd62, 6'd63, 1'b0);
        checkOutput("full_drop_count", 32'(count_o), 32'd16);
        checkOutput("full_drop_idx", 32'(rob_idx_1), 32'd4);
        completeIdx(4'd4, 1'b1, 4'd5, 1'b1);
        checkOutput("full_stall_hold", 32'(stall_o), 32'd1);
        step();
        checkOutput("full_relieved", 32'(stall_o), 32'd0);
        checkOutput("full_count_after", 32'(count_o), 32'd14);
        for (int k = 1; k < 8; k++) begin
            wIdx = 4'(4 + 2 * k);
            completeIdx(wIdx, 1'b1, wIdx + 4'd1, 1'b1);
        end
        step();
        checkOutput("full_drained", 32'(count_o), 32'd0);
        checkOutput("full_sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] completion to invalid entry");
        completeIdx(4'd7, 1'b1, 4'd0, 1'b0);
        applyStimulus(5'd6, 6'd1, 6'd20, 5'd7, 6'd2, 6'd21, 1'b1);
        checkOutput("inv_idx7", 32'(rob_idx_2), 32'd7);
        applyStimulus(5'd8, 6'd3, 6'd22, 5'd9, 6'd4, 6'd23, 1'b1);
        completeIdx(4'd4, 1'b1, 4'd5, 1'b1);
        completeIdx(4'd6, 1'b1, 4'd0, 1'b0);
        checkOutput("inv_pair_retire", 32'(rt_cnt_o), 32'd2);
        step();
        checkOutput("inv_single_retire", 32'(rt_cnt_o), 32'd1);
        step();
        checkOutput("inv_held", 32'(rt_cnt_o), 32'd0);
        checkOutput("inv_count", 32'(count_o), 32'd1);
        completeIdx(4'd7, 1'b1, 4'd0, 1'b0);
        step();
        checkOutput("inv_late_retire", 32'(rt_cnt_o), 32'd1);
        checkOutput("inv_empty", 32'(empty_o), 32'd1);

        $display("[TB] mid-stream reset");
        for (int k = 0; k < 3; k++)
            applyStimulus(5'd1, 6'd5, 6'(k), 5'd2, 6'd6, 6'(k + 8), 1'b1);
        checkOutput("mrst_count6", 32'(count_o), 32'd6);
        #3 reset = 1'b1;
        sb.delete();
        #1;
        checkOutput("mrst_async_count", 32'(count_o), 32'd0);
        @(posedge clock);
        #1;
        checkOutput("mrst_count", 32'(count_o), 32'd0);
        checkOutput("mrst_empty", 32'(empty_o), 32'd1);
        checkOutput("mrst_flag1", 32'(rt_flag_1), 32'd0);
        checkOutput("mrst_flag2", 32'(rt_flag_2), 32'd0);
        reset = 1'b0;
        checkOutput("mrst_idx1", 32'(rob_idx_1), 32'd0);
        checkOutput("mrst_idx2", 32'(rob_idx_2), 32'd1);
        applyStimulus(5'd9, 6'd44, 6'd9, 5'd10, 6'd45, 6'd10, 1'b1);
        checkOutput("mrst_count2", 32'(count_o), 32'd2);
        completeIdx(4'd0, 1'b1, 4'd1, 1'b1);
        step();

        $display("[TB] wrap-around");
        popsBefore = popCount;
        prevIdx = 4'd0;
        for (int k = 0; k < 20; k++) begin
            wIdx = 4'(2 + 2 * k);
            checkOutput("wrap_idx1", 32'(rob_idx_1), 32'(wIdx));
            checkOutput("wrap_idx2", 32'(rob_idx_2), 32'(wIdx + 4'd1));
            cmp_valid_1 = (k > 0); cmp_idx_1 = prevIdx;
            cmp_valid_2 = (k > 0); cmp_idx_2 = prevIdx + 4'd1;
            applyStimulus(5'(k + 1), 6'd0, 6'(2 * k), 5'(k + 2), 6'd0, 6'(2 * k + 1), 1'b1);
            prevIdx = wIdx;
        end
        completeIdx(prevIdx, 1'b1, prevIdx + 4'd1, 1'b1);
        step();
        step();
        checkOutput("wrap_retired", 32'(popCount - popsBefore), 32'd40);
        checkOutput("wrap_sb_empty", 32'(sb.size()), 32'd0);
        checkOutput("wrap_empty", 32'(empty_o), 32'd1);
`ifdef ROB_PERF_CNT_EN
        checkOutput("perf_total", retired_total_o, 32'd42);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
